// File: rtl/mmm_r2_precompute_if.sv
// mmm_r2_precompute_if: start/done handshake, modulus and result bus of the R/R^2 precompute block.
interface mmm_r2_precompute_if #(parameter int K = 8);
    logic         start;
    logic [K-1:0] m;
    logic [K-1:0] R_mod;
    logic [K-1:0] R2_mod;
    logic         busy;
    logic         done;
    logic         err;
    modport master(output start, m, input R_mod, R2_mod, busy, done, err);
    modport slave(input start, m, output R_mod, R2_mod, busy, done, err);
endinterface

// File: rtl/mmm_r2_precompute.sv
// mmm_r2_precompute: R mod m and R^2 mod m (R = 2^K) by repeated modular doubling of r = 1.
// Define MMM_R2_FAST_EN to chain two doublings per cycle (K-cycle latency, identical results).
module mmm_r2_precompute #(
    parameter int K = 8
) (
    input logic                    clk,
    input logic                    rst,
    mmm_r2_precompute_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    localparam int CW = $clog2(2 * K + 1);

    state_t       state;
    logic [K-1:0] mm;
    logic [K:0]   r, r1, nxt;
    logic [K-1:0] k_val;
    logic [CW-1:0] cnt;
    logic         k_hit, last;

    // r < m keeps 2r within K+1 bits, so one conditional subtract restores r < m
    function automatic logic [K:0] dbl(input logic [K:0] x, input logic [K-1:0] md);
        logic [K:0] t;
        t = x << 1;
        return t >= {1'b0, md} ? t - {1'b0, md} : t;
    endfunction

    assign r1 = dbl(r, mm);
`ifdef MMM_R2_FAST_EN
    localparam int STEP = 2;
    logic [K:0] r2;
    assign r2    = dbl(r1, mm);
    assign nxt   = r2;
    // cnt is always even here; odd K lands doubling K on the first stage
    assign k_hit = cnt == CW'(K - 1) || cnt == CW'(K - 2);
    assign k_val = cnt == CW'(K - 1) ? r1[K-1:0] : r2[K-1:0];
`else
    localparam int STEP = 1;
    assign nxt   = r1;
    assign k_hit = cnt == CW'(K - 1);
    assign k_val = r1[K-1:0];
`endif
    assign last = cnt == CW'(2 * K - STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mm         <= '0;
            r          <= '0;
            cnt        <= '0;
            bus.R_mod  <= '0;
            bus.R2_mod <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mm      <= bus.m;
                    bus.err <= 1'b0;
                    if (bus.m[0] && bus.m != K'(1)) begin
                        r        <= (K+1)'(1);
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ITER;
                    end else begin
                        bus.R_mod  <= '0;
                        bus.R2_mod <= '0;
                        bus.err    <= 1'b1;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                ITER: begin
                    r   <= nxt;
                    cnt <= cnt + CW'(STEP);
                    if (k_hit) bus.R_mod <= k_val;
                    if (last) begin
                        bus.R2_mod <= nxt[K-1:0];
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: if (!bus.start) begin
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmm_r2_precompute.sv
// tb_mmm_r2_precompute: directed vectors with hand-computed R mod m / R^2 mod m for K = 8.
module tb_mmm_r2_precompute;
    localparam int K = 8;
`ifdef MMM_R2_FAST_EN
    localparam int LAT = K;
`else
    localparam int LAT = 2 * K;
`endif

    logic clk, rst;
    int n_cmp = 0, n_bad = 0;

    mmm_r2_precompute_if #(.K(K)) bus ();
    mmm_r2_precompute #(.K(K)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // accept one run; toggling scrambles m/start during ITER, which must be ignored
    task automatic run(input logic [7:0] mv, input bit toggle, output int edges, output int busy_n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = mv;
        @(posedge clk);
        #1 bus.start = 1'b0;
        edges  = 0;
        busy_n = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_n++;
            if (toggle) begin
                bus.m     = 8'h0D;
                bus.start = edges[0];
            end
            @(posedge clk);
            #1 edges++;
        end
    endtask

    task automatic valid_run(input string tag, input logic [7:0] mv, input logic [7:0] er, input logic [7:0] er2);
        int e, b;
        run(mv, 1'b0, e, b);
        chk({tag, "_lat"}, e, LAT);
        chk({tag, "_busy"}, b, LAT);
        chk({tag, "_rmod"}, bus.R_mod, er);
        chk({tag, "_r2mod"}, bus.R2_mod, er2);
        chk({tag, "_err"}, bus.err, 0);
        @(posedge clk);
        #1 chk({tag, "_done_drop"}, bus.done, 0);
    endtask

    task automatic bad_run(input string tag, input logic [7:0] mv);
        int e, b;
        run(mv, 1'b0, e, b);
        chk({tag, "_lat"}, e, 0);
        chk({tag, "_err"}, bus.err, 1);
        chk({tag, "_rmod"}, bus.R_mod, 0);
        chk({tag, "_r2mod"}, bus.R2_mod, 0);
        @(posedge clk);
        #1 chk({tag, "_done_drop"}, bus.done, 0);
    endtask

    initial begin
        int e, b;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.m     = '0;
        #12;
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rmod", bus.R_mod, 0);
        rst = 1'b1;

        valid_run("f1", 8'hF1, 8'h0F, 8'hE1);
        valid_run("0d", 8'h0D, 8'h09, 8'h03);
        valid_run("ff", 8'hFF, 8'h01, 8'h01);
        valid_run("03", 8'h03, 8'h01, 8'h01);

        bad_run("even", 8'h10);
        bad_run("one", 8'h01);
        valid_run("f1_after_err", 8'hF1, 8'h0F, 8'hE1);

        run(8'hF1, 1'b1, e, b);
        chk("tog_lat", e, LAT);
        chk("tog_r2mod", bus.R2_mod, 8'hE1);
        chk("tog_rmod", bus.R_mod, 8'h0F);
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("hold_done", bus.done, 1);
        chk("hold_busy", bus.busy, 0);
        bus.start = 1'b0;
        @(posedge clk);
        #1 chk("tog_done_drop", bus.done, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = 8'hF1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_rmod", bus.R_mod, 0);
        chk("arst_r2mod", bus.R2_mod, 0);
        @(negedge clk);
        rst = 1'b1;
        valid_run("0d_after_rst", 8'h0D, 8'h09, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmm_r2_precompute.md
Name: mmm_r2_precompute

Overview:
- Upstream companion to the Montgomery multiplier. Computes the two Montgomery-domain constants for an odd modulus m: R mod m and R² mod m, where R = 2^K.
- R² mod m feeds the multiplier's B operand to convert operands into the Montgomery domain. R mod m is the Montgomery representation of 1, used as the initial accumulator for exponentiation.
- Sequential shift-and-subtract engine with a start/done handshake that matches the multiplier's.

Parameters:
- K, 8, operand/modulus width in bits; must be ≥ 2.

Ports:
- clk     input   1   system clock, rising-edge.
- rst     input   1   asynchronous, active-low reset (asserted when 0).
- start   input   1   request; sampled only in IDLE.
- m       input   K   modulus; sampled on the accepting edge.
- R_mod   output  K   R mod m.
- R2_mod  output  K   R² mod m.
- busy    output  1   high while in ITER.
- done    output  1   high while in DONE.
- err     output  1   high with done when the captured m was invalid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; R_mod, R2_mod, busy, done, err, internal residue and counter all reset to 0.
- Internal residue r is K+1 bits wide; the latched modulus is K bits. Each doubling step is: r ← 2r; if r ≥ m then r ← r − m. The invariant r < m guarantees 2r fits in K+1 bits.
- States: IDLE, ITER, DONE (2-bit encoding).
- IDLE: busy=0, done=0. On an edge with start=1, the block latches m and clears err.
  - If m is valid (m[0]=1 and m ≠ 1): set r←1, cnt←0, go to ITER.
  - If m is invalid (even, or m=1): R_mod←0, R2_mod←0, err←1, done←1, go directly to DONE. Latency is 1 edge.
- ITER: busy=1. Each edge performs one doubling step and increments cnt.
  - On the edge performing doubling number K, R_mod captures the post-step r[K-1:0].
  - On the edge performing doubling number 2K, R2_mod captures the post-step r[K-1:0]; busy←0, done←1, go to DONE.
  - Total: 2K edges after the accepting edge. cnt width is $clog2(2K+1).
- DONE: done=1 (and err if set). Outputs hold. Returns to IDLE on the first edge with start=0.
  - Holding start high keeps the block in DONE. There is no auto-restart.
- start while in ITER: ignored. The m input may change freely after the accepting edge without affecting the result.
- R_mod and R2_mod are stable from DONE entry until the next accepted start.
  - R_mod is updated mid-run at doubling K; consumers must read only when done=1.
- Reset mid-ITER: immediate abort to the reset values. No partial result is reported.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: MMM_R2_FAST_EN.
- Defined: the datapath chains two doubling steps per cycle.
  - ITER takes ceil(K) … specifically K cycles for 2K doublings.
  - R_mod captures the intermediate value after doubling K. For odd K, this is the first-stage output within that cycle.
  - done asserts K edges after the accepting edge.
- Undefined: one doubling per cycle, 2K-cycle latency as described above.
- Results are bit-identical in both builds. The invalid-m path is unchanged.

Test Plan:
- K=8, m=0xF1, start pulse → after 16 edges done=1, R_mod=0x0F, R2_mod=0xE1, err=0; busy high for exactly 16 cycles.
- m=0x0D, then m=0xFF, then m=0x03, each run followed by start=0 → (R_mod, R2_mod) = (0x09, 0x03), (0x01, 0x01), (0x01, 0x01); done drops 1 edge after start deasserts.
- m=0x10, then m=0x01 → done and err on the edge after acceptance, R_mod=R2_mod=0x00; a following valid run with m=0xF1 clears err.
- m=0xF1 accepted, then m changed to 0x0D and start toggled during ITER → still R2_mod=0xE1 at 16 edges; no second run starts until DONE→IDLE.
- rst=0 pulsed asynchronously (mid-clock) at ITER cycle 5 → all outputs 0 immediately, state IDLE; next run with m=0x0D produces correct results.
- MMM_R2_FAST_EN defined, m=0xF1 → done after 8 edges, R_mod=0x0F, R2_mod=0xE1.
